// File: rtl/pwm_led.sv
// -----------------------------------------------------------------------------
// pwm_led
//
// Purpose:
//    Three-channel breathing-LED generator. A free-running PWM period counter
//    is compared against a 6-bit brightness level to produce duty-cycled LED
//    drives. The level walks up and down in a triangle (0..63..0), taking one
//    step every T_s PWM periods, so the LEDs appear to "breathe".
//
// Parameters:
//    CNT_MAX  PWM period in sys_clk cycles (must be >= 64)
//    T_s      PWM periods per brightness step (0 behaves as 1)
//
// Ports:
//    sys_clk    in   1  system clock, all logic on the rising edge
//    sys_rst_n  in   1  asynchronous active-low reset
//    stear_s    out  6  current brightness level 0..63 (registered)
//    led_out    out  3  LED drives, active-high (registered)
//                         [0] duty stear_s/64
//                         [1] complementary duty (63-stear_s)/64
//                         [2] ramp direction (1 = getting brighter)
// -----------------------------------------------------------------------------
module pwm_led #(
   parameter logic [25:0] CNT_MAX = 26'd50_000,
   parameter logic [14:0] T_s     = 15'd10
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   output logic [5:0] stear_s,
   output logic [2:0] led_out
);

   // One brightness unit in clocks. Integer division, so for a CNT_MAX that
   // is not a multiple of 64 the top level never reaches the full period.
   localparam logic [25:0] STEP     = CNT_MAX / 26'd64;
   localparam logic [25:0] CNT_LAST = CNT_MAX - 26'd1;
   localparam logic [14:0] T_EFF    = (T_s == 15'd0) ? 15'd1 : T_s;
   localparam logic [14:0] T_LAST   = T_EFF - 15'd1;

   logic [25:0] cnt;
   logic [14:0] cnt_t;
   logic        dir;
   logic        period_end;
   logic        step_end;
   logic [31:0] cnt_wide;
   logic [31:0] thresh_up;
   logic [31:0] thresh_down;

   assign period_end = (cnt == CNT_LAST);
   assign step_end   = period_end && (cnt_t == T_LAST);

   // Thresholds are formed at 32 bits so 63*STEP can never wrap, whatever
   // CNT_MAX is chosen.
   assign cnt_wide    = 32'(cnt);
   assign thresh_up   = 32'(stear_s) * 32'(STEP);
   assign thresh_down = 32'(6'd63 - stear_s) * 32'(STEP);

   // PWM period counter: 0..CNT_MAX-1 then wrap.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt <= 26'd0;
      end else if (period_end) begin
         cnt <= 26'd0;
      end else begin
         cnt <= cnt + 26'd1;
      end
   end

   // Counts completed periods; wraps on the same edge a level step fires.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_t <= 15'd0;
      end else if (period_end) begin
         if (cnt_t == T_LAST) begin
            cnt_t <= 15'd0;
         end else begin
            cnt_t <= cnt_t + 15'd1;
         end
      end
   end

   // Triangle ramp. At each end the level bounces back immediately, so 63
   // and 0 each last exactly one step and a full breath is 126 steps.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         stear_s <= 6'd0;
         dir     <= 1'b1;
      end else if (step_end) begin
         if (dir) begin
            if (stear_s == 6'd63) begin
               stear_s <= 6'd62;
               dir     <= 1'b0;
            end else begin
               stear_s <= stear_s + 6'd1;
            end
         end else begin
            if (stear_s == 6'd0) begin
               stear_s <= 6'd1;
               dir     <= 1'b1;
            end else begin
               stear_s <= stear_s - 6'd1;
            end
         end
      end
   end

   // LED drives are registered, so they lag cnt/stear_s/dir by one clock.
   // Strict less-than: level 0 is always off and level 63 is never 100 %.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         led_out <= 3'b000;
      end else begin
         led_out <= {dir, (cnt_wide < thresh_down), (cnt_wide < thresh_up)};
      end
   end

endmodule

// File: tb/tb_pwm_led.sv
// -----------------------------------------------------------------------------
// tb_pwm_led
//
// Purpose:
//    Self-checking bench for pwm_led. Three instances run side by side:
//       A  CNT_MAX=64,    T_s=3  ramp turnarounds, full breath, async reset
//       B  CNT_MAX=20000, T_s=1  first step timing and real-size duty widths
//       C  CNT_MAX=64,    T_s=0  T_s=0 corner
//    Expected values are hand-computed and pushed into a time-ordered queue;
//    a separate monitor pops each entry when its sample time arrives.
//    Sample times sit on falling edges (or between edges around the
//    asynchronous reset), away from the active rising edge.
//
// Ports:
//    none
// -----------------------------------------------------------------------------
module tb_pwm_led;

   typedef struct {
      longint t;
      int     inst;
      int     what;
      int     exp;
      int     id;
   } exp_t;

   // Release time of the first reset; cycle k after it is sampled at T0+10k.
   localparam longint T0 = 30;
   // Release time of the mid-operation reset on instance A.
   localparam longint T1 = 281100;

   logic       sys_clk = 1'b0;
   logic       rst_a   = 1'b0;
   logic       rst_bc  = 1'b0;
   logic [5:0] stear_a, stear_b, stear_c;
   logic [2:0] led_a, led_b, led_c;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   next_id  = 0;

   always #5 sys_clk = ~sys_clk;

   pwm_led #(.CNT_MAX(26'd64), .T_s(15'd3)) dut_a (
      .sys_clk   (sys_clk),
      .sys_rst_n (rst_a),
      .stear_s   (stear_a),
      .led_out   (led_a)
   );

   pwm_led #(.CNT_MAX(26'd20000), .T_s(15'd1)) dut_b (
      .sys_clk   (sys_clk),
      .sys_rst_n (rst_bc),
      .stear_s   (stear_b),
      .led_out   (led_b)
   );

   pwm_led #(.CNT_MAX(26'd64), .T_s(15'd0)) dut_c (
      .sys_clk   (sys_clk),
      .sys_rst_n (rst_bc),
      .stear_s   (stear_c),
      .led_out   (led_c)
   );

   function automatic longint at(input longint base, input int k);
      return base + 64'(10 * k);
   endfunction

   // Queue is kept sorted by sample time so the monitor only looks at the head.
   function automatic void pushExpect(input longint t, input int inst,
                                      input int what, input int exp);
      exp_t e;
      int   i;
      e.t    = t;
      e.inst = inst;
      e.what = what;
      e.exp  = exp;
      e.id   = next_id;
      next_id++;
      i = exp_q.size();
      while (i > 0 && exp_q[i-1].t > t) i--;
      exp_q.insert(i, e);
   endfunction

   function automatic int actualOf(input int inst, input int what);
      int v;
      v = 0;
      case (inst)
         0: v = (what == 0) ? int'(led_a) : int'(stear_a);
         1: v = (what == 0) ? int'(led_b) : int'(stear_b);
         default: v = (what == 0) ? int'(led_c) : int'(stear_c);
      endcase
      return v;
   endfunction

   function automatic string labelOf(input int inst, input int what);
      string s;
      s = (inst == 0) ? "A" : (inst == 1) ? "B" : "C";
      return {s, (what == 0) ? ".led_out" : ".stear_s"};
   endfunction

   task automatic checkOutput(input exp_t e);
      int act;
      act = actualOf(e.inst, e.what);
      n_checks++;
      if (act == e.exp) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL check%0d %s @%0t: got %0d, expected %0d",
                  e.id, labelOf(e.inst, e.what), $time, act, e.exp);
      end
   endtask

   task automatic applyStimulus(input logic a, input logic bc);
      rst_a  = a;
      rst_bc = bc;
   endtask

   task automatic waitUntil(input longint t);
      if (t > $time) #(t - $time);
   endtask

   // Monitor: pops every expectation whose sample time has arrived.
   initial begin
      exp_t e;
      forever begin
         #1;
         while (exp_q.size() > 0 && exp_q[0].t <= $time) begin
            e = exp_q.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      // ---- while held in reset ----
      pushExpect(22, 0, 0, 0);
      pushExpect(22, 0, 1, 0);
      pushExpect(22, 1, 0, 0);
      pushExpect(22, 1, 1, 0);
      pushExpect(22, 2, 0, 0);

      // ---- first clock after release: 110 ----
      pushExpect(at(T0, 1), 0, 0, 6);
      pushExpect(at(T0, 1), 0, 1, 0);
      pushExpect(at(T0, 1), 1, 0, 6);
      pushExpect(at(T0, 1), 2, 0, 6);

      // ---- A: first period, channel 1 drops on cnt=63, first step ----
      pushExpect(at(T0, 64),  0, 0, 4);
      pushExpect(at(T0, 65),  0, 0, 6);
      pushExpect(at(T0, 191), 0, 1, 0);
      pushExpect(at(T0, 192), 0, 1, 1);
      pushExpect(at(T0, 192), 0, 0, 4);
      pushExpect(at(T0, 193), 0, 0, 7);
      pushExpect(at(T0, 194), 0, 0, 6);

      // ---- A: peak held one step, turnaround to 62 with dir=0 ----
      pushExpect(at(T0, 12095), 0, 1, 62);
      pushExpect(at(T0, 12096), 0, 1, 63);
      pushExpect(at(T0, 12097), 0, 0, 5);
      pushExpect(at(T0, 12159), 0, 0, 5);
      pushExpect(at(T0, 12160), 0, 0, 4);
      pushExpect(at(T0, 12287), 0, 1, 63);
      pushExpect(at(T0, 12288), 0, 1, 62);
      pushExpect(at(T0, 12288), 0, 0, 4);
      pushExpect(at(T0, 12289), 0, 0, 3);
      pushExpect(at(T0, 12290), 0, 0, 1);

      // ---- A: trough, level 0 held one step, back to 1 after 126 steps ----
      pushExpect(at(T0, 24191), 0, 1, 1);
      pushExpect(at(T0, 24192), 0, 1, 0);
      pushExpect(at(T0, 24200), 0, 0, 2);
      pushExpect(at(T0, 24383), 0, 1, 0);
      pushExpect(at(T0, 24384), 0, 1, 1);
      pushExpect(at(T0, 24384), 0, 0, 0);
      pushExpect(at(T0, 24385), 0, 0, 7);
      pushExpect(at(T0, 28100), 0, 1, 20);

      // ---- B: first step at CNT_MAX, duty 312 and 19344 clocks ----
      pushExpect(at(T0, 19999), 1, 1, 0);
      pushExpect(at(T0, 20000), 1, 1, 1);
      pushExpect(at(T0, 20000), 1, 0, 4);
      pushExpect(at(T0, 20001), 1, 0, 7);
      pushExpect(at(T0, 20312), 1, 0, 7);
      pushExpect(at(T0, 20313), 1, 0, 6);
      pushExpect(at(T0, 39344), 1, 0, 6);
      pushExpect(at(T0, 39345), 1, 0, 4);
      pushExpect(at(T0, 39999), 1, 1, 1);
      pushExpect(at(T0, 40000), 1, 1, 2);

      // ---- C: T_s=0 steps every 64 clocks, duty = level clocks ----
      pushExpect(at(T0, 63),   2, 1, 0);
      pushExpect(at(T0, 64),   2, 1, 1);
      pushExpect(at(T0, 128),  2, 1, 2);
      pushExpect(at(T0, 321),  2, 0, 7);
      pushExpect(at(T0, 325),  2, 0, 7);
      pushExpect(at(T0, 326),  2, 0, 6);
      pushExpect(at(T0, 4032), 2, 1, 63);
      pushExpect(at(T0, 4096), 2, 1, 62);

      waitUntil(T0);
      applyStimulus(1'b1, 1'b1);

      // ---- A: asynchronous reset between edges while level is 20 ----
      waitUntil(281000);
      pushExpect(281034, 0, 0, 0);
      pushExpect(281034, 0, 1, 0);
      pushExpect(281096, 0, 0, 0);
      pushExpect(at(T1, 1),   0, 0, 6);
      pushExpect(at(T1, 191), 0, 1, 0);
      pushExpect(at(T1, 192), 0, 1, 1);
      pushExpect(at(T1, 193), 0, 0, 7);

      waitUntil(281032);
      applyStimulus(1'b0, 1'b1);
      waitUntil(T1);
      applyStimulus(1'b1, 1'b1);

      waitUntil(at(T0, 40000) + 20);
      for (int i = 0; i < 50 && exp_q.size() > 0; i++) #10;
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_checks++;
         $display("[TB] FAIL check%0d %s: never sampled, expected %0d",
                  e.id, labelOf(e.inst, e.what), e.exp);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
